// File: rtl/branch_predictor_btb_if.sv
// Fetch/execute-facing bundle of the branch predictor: lookup request/prediction,
// resolved-branch feedback and the registered redirect.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface branch_predictor_btb_if #(
    parameter int PC_SIZE = `PC_SIZE,
    parameter int IDX     = 4
);
    logic [PC_SIZE-1:0] lookup_pc;
    logic               predict_taken;
    logic [PC_SIZE-1:0] predict_target;
    logic [IDX-1:0]     predict_ghr;

    logic               fb_valid;
    logic               fb_branch;
    logic               fb_jump;
    logic [PC_SIZE-1:0] fb_pc;
    logic [PC_SIZE-1:0] fb_predict_target;
    logic [PC_SIZE-1:0] fb_feedback_target;
    logic               fb_predict_taken;
    logic               fb_feedback_taken;
    logic [IDX-1:0]     fb_ghr;

    logic               mispredict;
    logic [PC_SIZE-1:0] redirect_pc;

    modport master (
        output lookup_pc, fb_valid, fb_branch, fb_jump, fb_pc, fb_predict_target,
               fb_feedback_target, fb_predict_taken, fb_feedback_taken, fb_ghr,
        input  predict_taken, predict_target, predict_ghr, mispredict, redirect_pc
    );

    modport slave (
        input  lookup_pc, fb_valid, fb_branch, fb_jump, fb_pc, fb_predict_target,
               fb_feedback_target, fb_predict_taken, fb_feedback_taken, fb_ghr,
        output predict_taken, predict_target, predict_ghr, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters (bimodal or gshare index),
// table-initialisation sweep after reset/clear, and registered mispredict redirect.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module branch_predictor_btb #(
    parameter int PC_SIZE  = `PC_SIZE,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int GSHARE   = 0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic ready,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_SIZE - IDX;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_reg, state_next;
    logic [IDX-1:0]     idx_reg, idx_next;
    logic [IDX-1:0]     ghr_reg, ghr_next, ghr_shift;
    logic               mispredict_reg, mispredict_next;
    logic [PC_SIZE-1:0] redirect_reg, redirect_next;

    logic               valid_mem  [ENTRIES];
    logic               jump_mem   [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [PC_SIZE-1:0] target_mem [ENTRIES];
    logic [CTR_BITS-1:0] ctr_mem   [ENTRIES];

    // Lookup path
    logic [IDX-1:0]   ghr_eff, lk_idx, lk_ctr_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit, lk_taken;

    assign ready      = (state_reg == ST_RUN);
    assign ghr_eff    = (GSHARE != 0) ? ghr_reg : '0;
    assign lk_idx     = bus.lookup_pc[IDX-1:0];
    assign lk_tag     = bus.lookup_pc[PC_SIZE-1:IDX];
    assign lk_ctr_idx = lk_idx ^ ghr_eff;
    assign lk_hit     = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_taken   = ready && lk_hit && (jump_mem[lk_idx] || ctr_mem[lk_ctr_idx][CTR_BITS-1]);

    assign bus.predict_taken  = lk_taken;
    assign bus.predict_target = lk_taken ? target_mem[lk_idx] : bus.lookup_pc + PC_SIZE'(1);
    assign bus.predict_ghr    = ghr_eff;
    assign bus.mispredict     = mispredict_reg;
    assign bus.redirect_pc    = redirect_reg;

    // Feedback path; clear in the same cycle drops the feedback entirely
    logic                fb_accept, fb_miss;
    logic [IDX-1:0]      fb_idx, fb_ctr_idx;
    logic [CTR_BITS-1:0] fb_ctr_old, fb_ctr_new;

    assign fb_accept  = (state_reg == ST_RUN) && !clear && bus.fb_valid
                        && (bus.fb_branch || bus.fb_jump);
    assign fb_idx     = bus.fb_pc[IDX-1:0];
    assign fb_ctr_idx = fb_idx ^ ((GSHARE != 0) ? bus.fb_ghr : '0);
    assign fb_ctr_old = ctr_mem[fb_ctr_idx];
    assign fb_miss    = (bus.fb_predict_taken != bus.fb_feedback_taken)
                        || (bus.fb_predict_taken && bus.fb_feedback_taken
                            && (bus.fb_predict_target != bus.fb_feedback_target));

    generate
        if (IDX > 1) begin : g_ghr_wide
            assign ghr_shift = {ghr_reg[IDX-2:0], bus.fb_feedback_taken};
        end else begin : g_ghr_one
            assign ghr_shift = bus.fb_feedback_taken;
        end
    endgenerate

    always_comb begin
        fb_ctr_new = fb_ctr_old;
        if (bus.fb_feedback_taken) begin
            if (fb_ctr_old != CTR_MAX) fb_ctr_new = fb_ctr_old + CTR_BITS'(1);
        end else begin
            if (fb_ctr_old != '0) fb_ctr_new = fb_ctr_old - CTR_BITS'(1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        ghr_next        = ghr_reg;
        mispredict_next = 1'b0;
        redirect_next   = redirect_reg;
        case (state_reg)
            ST_INIT: begin
                idx_next = idx_reg + IDX'(1);
                if (idx_reg == IDX'(ENTRIES - 1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (clear) begin
                    state_next = ST_INIT;
                    idx_next   = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
        if (fb_accept) begin
            if (fb_miss) begin
                mispredict_next = 1'b1;
                redirect_next   = bus.fb_feedback_taken ? bus.fb_feedback_target
                                                        : bus.fb_pc + PC_SIZE'(1);
            end
            if ((GSHARE != 0) && bus.fb_branch) ghr_next = ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_INIT;
            idx_reg        <= '0;
            ghr_reg        <= '0;
            mispredict_reg <= 1'b0;
            redirect_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            ghr_reg        <= ghr_next;
            mispredict_reg <= mispredict_next;
            redirect_reg   <= redirect_next;
        end
    end

    // Table storage is never reset; the INIT sweep brings it to a known state
    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT) begin
            valid_mem[idx_reg] <= 1'b0;
            ctr_mem[idx_reg]   <= CTR_WEAK_NT;
        end else if (fb_accept) begin
            if (bus.fb_branch) ctr_mem[fb_ctr_idx] <= fb_ctr_new;
            if (bus.fb_feedback_taken) begin
                valid_mem[fb_idx]  <= 1'b1;
                jump_mem[fb_idx]   <= bus.fb_jump;
                tag_mem[fb_idx]    <= bus.fb_pc[PC_SIZE-1:IDX];
                target_mem[fb_idx] <= bus.fb_feedback_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench: vector table through a bimodal instance with a redirect
// scoreboard, plus hand sequences for init, clear, reset and gshare indexing.
`timescale 1ns/1ps
module tb_branch_predictor_btb;
    logic clk;
    logic n_rst;
    logic clear, clear_g;
    logic ready, ready_g;

    branch_predictor_btb_if #(.PC_SIZE(16), .IDX(4)) bif();
    branch_predictor_btb_if #(.PC_SIZE(16), .IDX(4)) bif_g();

    branch_predictor_btb #(.PC_SIZE(16), .ENTRIES(16), .CTR_BITS(2), .GSHARE(0)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .ready(ready), .bus(bif.slave));

    branch_predictor_btb #(.PC_SIZE(16), .ENTRIES(16), .CTR_BITS(2), .GSHARE(1)) dut_g (
        .clk(clk), .n_rst(n_rst), .clear(clear_g), .ready(ready_g), .bus(bif_g.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lk;
        logic        v, br, jp;
        logic [15:0] pc;
        logic        pt;
        logic [15:0] ptgt;
        logic        ft;
        logic [15:0] ftgt;
        logic        e_tk;
        logic [15:0] e_tgt;
        logic        e_mp;
        logic [15:0] e_rd;
    } vec_t;

    typedef struct {
        logic        mp;
        logic [15:0] rd;
        int          id;
    } sb_t;

    vec_t        vecs [24];
    sb_t         sb_q [$];
    logic [15:0] last_rd;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(logic [15:0] lk, logic v, logic br, logic jp, logic [15:0] pc,
                                logic pt, logic [15:0] ptgt, logic ft, logic [15:0] ftgt,
                                logic e_tk, logic [15:0] e_tgt, logic e_mp, logic [15:0] e_rd);
        vec_t r;
        r.lk = lk; r.v = v; r.br = br; r.jp = jp; r.pc = pc; r.pt = pt; r.ptgt = ptgt;
        r.ft = ft; r.ftgt = ftgt; r.e_tk = e_tk; r.e_tgt = e_tgt; r.e_mp = e_mp; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_fb(input logic v, input logic br, input logic jp, input logic [15:0] pc,
                            input logic pt, input logic [15:0] ptgt, input logic ft,
                            input logic [15:0] ftgt);
        bif.fb_valid = v; bif.fb_branch = br; bif.fb_jump = jp; bif.fb_pc = pc;
        bif.fb_predict_taken = pt; bif.fb_predict_target = ptgt;
        bif.fb_feedback_taken = ft; bif.fb_feedback_target = ftgt; bif.fb_ghr = 4'h0;
    endtask

    // One table vector: drive at posedge+1, check lookup before the edge, pop redirect after it
    task automatic step(input int i);
        sb_t e, got;
        bif.lookup_pc = vecs[i].lk;
        drive_fb(vecs[i].v, vecs[i].br, vecs[i].jp, vecs[i].pc, vecs[i].pt, vecs[i].ptgt,
                 vecs[i].ft, vecs[i].ftgt);
        e.mp = vecs[i].e_mp;
        e.rd = vecs[i].e_mp ? vecs[i].e_rd : last_rd;
        e.id = i;
        last_rd = e.rd;
        sb_q.push_back(e);
        #3;
        chk($sformatf("v%0d predict_taken", i), {31'd0, bif.predict_taken}, {31'd0, vecs[i].e_tk});
        chk($sformatf("v%0d predict_target", i), {16'd0, bif.predict_target}, {16'd0, vecs[i].e_tgt});
        @(posedge clk); #1;
        got = sb_q.pop_front();
        chk($sformatf("v%0d mispredict", got.id), {31'd0, bif.mispredict}, {31'd0, got.mp});
        chk($sformatf("v%0d redirect_pc", got.id), {16'd0, bif.redirect_pc}, {16'd0, got.rd});
        $display("vec %0d lk=%h fb(v%0b b%0b j%0b pc=%h ft=%0b) -> tk=%0b tgt=%h mp=%0b rd=%h",
                 i, vecs[i].lk, vecs[i].v, vecs[i].br, vecs[i].jp, vecs[i].pc, vecs[i].ft,
                 vecs[i].e_tk, vecs[i].e_tgt, got.mp, got.rd);
    endtask

    task automatic gstep(input string nm, input logic [15:0] lk, input logic v, input logic [15:0] pc,
                         input logic [3:0] gh, input logic pt, input logic [15:0] ptgt,
                         input logic ft, input logic [15:0] ftgt,
                         input logic e_tk, input logic [15:0] e_tgt, input logic e_mp);
        bif_g.lookup_pc = lk; bif_g.fb_valid = v; bif_g.fb_branch = 1'b1; bif_g.fb_jump = 1'b0;
        bif_g.fb_pc = pc; bif_g.fb_ghr = gh; bif_g.fb_predict_taken = pt;
        bif_g.fb_predict_target = ptgt; bif_g.fb_feedback_taken = ft; bif_g.fb_feedback_target = ftgt;
        #3;
        chk({nm, " predict_taken"}, {31'd0, bif_g.predict_taken}, {31'd0, e_tk});
        chk({nm, " predict_target"}, {16'd0, bif_g.predict_target}, {16'd0, e_tgt});
        @(posedge clk); #1;
        chk({nm, " mispredict"}, {31'd0, bif_g.mispredict}, {31'd0, e_mp});
        $display("gshare %s lk=%h fb pc=%h ghr=%b ft=%0b -> tk=%0b tgt=%h mp=%0b",
                 nm, lk, pc, gh, ft, e_tk, e_tgt, e_mp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lk, v,br,jp, pc, pt,ptgt, ft,ftgt, exp taken,target, exp mp,redirect
        vecs[0]  = mk(16'h0020, 1,0,1, 16'h0020, 0,16'h0021, 1,16'h0100, 0,16'h0021, 1,16'h0100);
        vecs[1]  = mk(16'h0020, 0,0,0, 16'h0000, 0,16'h0000, 0,16'h0000, 1,16'h0100, 0,16'h0000);
        vecs[2]  = mk(16'h0005, 1,1,0, 16'h0005, 0,16'h0006, 1,16'h0200, 0,16'h0006, 1,16'h0200);
        vecs[3]  = mk(16'h0005, 1,1,0, 16'h0005, 1,16'h0200, 1,16'h0200, 1,16'h0200, 0,16'h0000);
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = vecs[3];
        vecs[7]  = mk(16'h0005, 1,1,0, 16'h0005, 1,16'h0200, 0,16'h0200, 1,16'h0200, 1,16'h0006);
        vecs[8]  = vecs[7];
        vecs[9]  = mk(16'h0005, 1,1,0, 16'h0005, 0,16'h0006, 0,16'h0200, 0,16'h0006, 0,16'h0000);
        vecs[10] = vecs[9];
        vecs[11] = mk(16'h0005, 1,1,0, 16'h0005, 0,16'h0006, 1,16'h0200, 0,16'h0006, 1,16'h0200);
        vecs[12] = vecs[11];
        vecs[13] = mk(16'h0005, 0,0,0, 16'h0000, 0,16'h0000, 0,16'h0000, 1,16'h0200, 0,16'h0000);
        vecs[14] = mk(16'h0003, 1,1,0, 16'h0003, 0,16'h0004, 1,16'h0300, 0,16'h0004, 1,16'h0300);
        vecs[15] = mk(16'h0013, 0,0,0, 16'h0000, 0,16'h0000, 0,16'h0000, 0,16'h0014, 0,16'h0000);
        vecs[16] = mk(16'h0003, 0,0,0, 16'h0000, 0,16'h0000, 0,16'h0000, 1,16'h0300, 0,16'h0000);
        vecs[17] = mk(16'h0020, 1,0,1, 16'h0020, 1,16'h0100, 1,16'h0180, 1,16'h0100, 1,16'h0180);
        vecs[18] = mk(16'h0020, 0,1,0, 16'h0040, 0,16'h0041, 1,16'h0400, 1,16'h0180, 0,16'h0000);
        vecs[19] = mk(16'h0040, 1,0,0, 16'h0040, 0,16'h0041, 1,16'h0400, 0,16'h0041, 0,16'h0000);
        vecs[20] = mk(16'h0030, 1,0,1, 16'h0030, 0,16'h0031, 1,16'h0500, 0,16'h0031, 1,16'h0500);
        vecs[21] = mk(16'h0030, 1,1,0, 16'h0007, 1,16'h0700, 0,16'h0700, 1,16'h0500, 1,16'h0008);
        vecs[22] = mk(16'h0020, 1,0,1, 16'h0030, 1,16'h0500, 1,16'h0500, 0,16'h0021, 0,16'h0000);
        vecs[23] = mk(16'hFFFF, 1,1,0, 16'hFFFF, 1,16'h0000, 0,16'h0000, 0,16'h0000, 1,16'h0000);

        n_rst = 1'b0; clear = 1'b0; clear_g = 1'b0; last_rd = 16'h0000;
        bif.lookup_pc = 16'h0010;
        drive_fb(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        bif_g.lookup_pc = 16'h0000; bif_g.fb_valid = 1'b0; bif_g.fb_branch = 1'b0;
        bif_g.fb_jump = 1'b0; bif_g.fb_pc = 16'h0; bif_g.fb_predict_target = 16'h0;
        bif_g.fb_feedback_target = 16'h0; bif_g.fb_predict_taken = 1'b0;
        bif_g.fb_feedback_taken = 1'b0; bif_g.fb_ghr = 4'h0;
        #2;
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset mispredict", {31'd0, bif.mispredict}, 32'd0);
        chk("reset redirect_pc", {16'd0, bif.redirect_pc}, 32'd0);
        chk("reset predict_ghr gshare", {28'd0, bif_g.predict_ghr}, 32'd0);

        // Init sweep with a mispredicting jump held on feedback the whole time
        @(posedge clk); #1;
        n_rst = 1'b1;
        drive_fb(1, 0, 1, 16'h0051, 0, 16'h0052, 1, 16'h0600);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            chk($sformatf("init c%0d ready", c), {31'd0, ready}, {31'd0, (c == 16)});
            chk($sformatf("init c%0d mispredict", c), {31'd0, bif.mispredict}, 32'd0);
            if (c < 16)
                chk($sformatf("init c%0d predict_taken", c), {31'd0, bif.predict_taken}, 32'd0);
            $display("init cycle %0d ready=%0b", c, ready);
        end
        drive_fb(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        chk("init predict_target", {16'd0, bif.predict_target}, 32'h0011);
        chk("init ready gshare", {31'd0, ready_g}, 32'd1);
        bif.lookup_pc = 16'h0051;
        #1;
        chk("init fb dropped taken", {31'd0, bif.predict_taken}, 32'd0);
        chk("init fb dropped target", {16'd0, bif.predict_target}, 32'h0052);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) step(i);
        drive_fb(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        chk("bimodal predict_ghr", {28'd0, bif.predict_ghr}, 32'd0);
        chk("scoreboard drained", sb_q.size(), 32'd0);

        // Clear together with a mispredicting feedback: clear wins
        bif.lookup_pc = 16'h0030;
        clear = 1'b1;
        drive_fb(1, 0, 1, 16'h0030, 0, 16'h0031, 1, 16'h0900);
        @(posedge clk); #1;
        clear = 1'b0;
        drive_fb(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        chk("clear mispredict", {31'd0, bif.mispredict}, 32'd0);
        chk("clear ready", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            chk($sformatf("clear c%0d ready", c), {31'd0, ready}, {31'd0, (c == 16)});
        end
        $display("clear sweep done ready=%0b", ready);
        chk("clear table taken", {31'd0, bif.predict_taken}, 32'd0);
        chk("clear table target", {16'd0, bif.predict_target}, 32'h0031);

        // Mid-RUN reset right after a mispredict pulse
        drive_fb(1, 0, 1, 16'h0044, 0, 16'h0045, 1, 16'h0777);
        @(posedge clk); #1;
        drive_fb(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        chk("pre-reset mispredict", {31'd0, bif.mispredict}, 32'd1);
        chk("pre-reset redirect_pc", {16'd0, bif.redirect_pc}, 32'h0777);
        n_rst = 1'b0;
        #1;
        chk("async reset mispredict", {31'd0, bif.mispredict}, 32'd0);
        chk("async reset redirect_pc", {16'd0, bif.redirect_pc}, 32'd0);
        chk("async reset ready", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        // Reset mid-sweep: sweep must restart from index 0
        n_rst = 1'b0;
        #1;
        chk("midsweep reset ready", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            chk($sformatf("resweep c%0d ready", c), {31'd0, ready}, {31'd0, (c == 16)});
        end
        $display("resweep done ready=%0b ready_g=%0b", ready, ready_g);
        chk("resweep ready gshare", {31'd0, ready_g}, 32'd1);

        // Gshare: counter index = pc ^ fb_ghr for training, pc ^ ghr for lookup
        gstep("g1", 16'h0002, 1, 16'h0002, 4'b0101, 0, 16'h0003, 1, 16'h0040, 0, 16'h0003, 1);
        gstep("g2", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        gstep("g3", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        gstep("g4", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        gstep("g5", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        chk("g ghr cleared", {28'd0, bif_g.predict_ghr}, 32'd0);
        gstep("g6", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        gstep("g7", 16'h0002, 1, 16'h0008, 4'b0000, 1, 16'h0080, 1, 16'h0080, 0, 16'h0003, 0);
        gstep("g8", 16'h0002, 1, 16'h0008, 4'b0000, 0, 16'h0009, 0, 16'h0000, 0, 16'h0003, 0);
        gstep("g9", 16'h0002, 1, 16'h0008, 4'b0000, 1, 16'h0080, 1, 16'h0080, 0, 16'h0003, 0);
        chk("g ghr 0101", {28'd0, bif_g.predict_ghr}, 32'h5);
        gstep("g10", 16'h0002, 0, 16'h0000, 4'b0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch predictor for the pipelined NAND CPU: a direct-mapped branch target buffer with saturating direction counters, selectable bimodal or gshare indexing, and a post-reset/clear table-initialisation sweep. Fetch presents a PC and gets a combinational taken/target prediction. Execute returns resolved branch/jump feedback, which trains the tables and produces a registered redirect on misprediction.

## Interface
- PC_SIZE, default `PC_SIZE: PC width.
- ENTRIES, default 16: BTB and counter-table depth; power of two, at least 2. IDX = log2(ENTRIES).
- CTR_BITS, default 2: direction counter width, 1 to 4.
- GSHARE, default 0: 0 selects bimodal (counter index = pc[IDX-1:0]); 1 selects gshare (counter index = pc[IDX-1:0] ^ ghr).
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- clear  in  1  restarts the initialisation sweep; ignored while it is already low.
- lookup_pc  in  PC_SIZE  fetch PC.
- predict_taken  out  1  predicted taken.
- predict_target  out  PC_SIZE  predicted next PC.
- predict_ghr  out  IDX  GHR snapshot that travels down the pipe with the instruction.
- fb_valid  in  1  feedback present this cycle.
- fb_branch, fb_jump  in  1 each  resolved instruction is a conditional branch / unconditional jump.
- fb_pc, fb_predict_target, fb_feedback_target  in  PC_SIZE each.
- fb_predict_taken, fb_feedback_taken  in  1 each.
- fb_ghr  in  IDX  predict_ghr value captured at lookup.
- ready  out  1  tables initialised.
- mispredict  out  1  registered redirect strobe.
- redirect_pc  out  PC_SIZE  registered correct next PC.

## Operation
- Storage per entry: valid, is_jump, tag = pc[PC_SIZE-1:IDX], target. A separate array holds CTR_BITS counters.
- FSM states:
  - INIT: sweeps idx 0..ENTRIES-1 at one entry per cycle. Each step clears valid and sets the counter to the weakly-not-taken value, 2^(CTR_BITS-1)-1. After idx ENTRIES-1 the FSM moves to RUN.
  - RUN: normal operation. clear=1 returns the FSM to INIT with idx 0.
- ready = (state == RUN).
- Lookup (combinational):
  - hit = valid && tag match at pc[IDX-1:0].
  - predict_taken = ready && hit && (is_jump || counter MSB).
  - predict_target = predict_taken ? target : lookup_pc + 1, modulo 2^PC_SIZE.
  - predict_ghr = ghr. In bimodal mode this output is driven to 0.
- Training happens when RUN, fb_valid, and (fb_branch or fb_jump) are all true:
  - Counter update, fb_branch only: index uses fb_pc, and fb_ghr in gshare mode. Saturating increment when taken, decrement when not taken; no wrap at 0 or at 2^CTR_BITS-1.
  - BTB update when feedback taken: write valid=1, tag, target=fb_feedback_target, is_jump=fb_jump.
  - BTB update on a not-taken branch: no allocation, and any existing entry is kept.
  - GHR (gshare only) = {ghr[IDX-2:0], fb_feedback_taken} on fb_branch. Jumps leave the GHR unchanged.
- Misprediction is detected when fb_predict_taken != fb_feedback_taken, or when both are taken and fb_predict_target != fb_feedback_target.
  - On the next edge: mispredict=1 and redirect_pc = fb_feedback_taken ? fb_feedback_target : fb_pc+1.
  - Otherwise mispredict=0 and redirect_pc holds its value.
- Feedback received during INIT is dropped: no training and no mispredict.

## Timing
- Reset values: state=INIT, idx=0, ghr=0, mispredict=0, redirect_pc=0, ready=0. Table contents are not reset; the sweep initialises them.
- The first RUN cycle is ENTRIES cycles after reset release, so ready rises on edge ENTRIES.
- Lookup is zero-latency. Training writes take effect at the next edge.
- A same-cycle lookup and write to the same index reads the old contents (read-first).
- Mispredict latency is 1 cycle and the strobe is a single-cycle pulse per mispredicting feedback. Back-to-back feedback gives back-to-back pulses.
- clear asserted in the same cycle as feedback: clear wins and the feedback is dropped.
- Asserting n_rst mid-sweep or mid-RUN immediately forces all reset values.

## Test plan
- Reset init, ENTRIES=16: release n_rst, then lookup_pc=0x0010 → ready=0 and predict_taken=0 for 16 cycles; ready=1 on cycle 16; predict_target=0x0011.
- Jump allocate: feedback jump fb_pc=0x0020, taken, target 0x0100, predicted not-taken → next cycle mispredict=1 and redirect_pc=0x0100; then lookup 0x0020 → taken, target 0x0100.
- Counter saturation, CTR_BITS=2: five taken feedbacks at pc 0x0005 → counter 3; one not-taken → counter 2, prediction still taken; two more not-taken → predict_taken=0.
- Tag alias: allocate pc 0x0003, then lookup 0x0013 → hit=0, predict_taken=0, target 0x0014.
- Gshare: GSHARE=1, ghr=4'b0101, training at pc 0x0002 → counter index 0x7 updated and index 0x2 unchanged.
- Clear and feedback in the same cycle: no mispredict and ready=0 for 16 cycles; assert n_rst mid-sweep → idx restarts at 0.
